// File: rtl/memwb_skid_stage.sv
// memwb_skid_stage: MEM/WB pipeline stage with valid/ready handshake, 2-entry skid buffer, flush, r0 guard, WB mux and stall counter
// Ports: in_* beat from MEM (in_ready registered), out_* head entry to WB, wb_data selected writeback
// value, flush drops all held beats plus the incoming one, stall_cnt counts back-pressured cycles.
module memwb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_memdata,
  input  logic [REG_W-1:0]  in_wreg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_memdata,
  output logic [REG_W-1:0]  out_wreg,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int PW = 2 + 2 * DATA_W + REG_W;
  logic          r_h_valid, r_s_valid, r_in_ready;
  logic [PW-1:0] r_h_pl, r_s_pl;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [PW-1:0] w_in_pl;
  logic          w_acc, w_pop, w_ld_h_s, w_ld_h_in, w_ld_s_in, w_h_nxt, w_s_nxt;
  assign w_in_pl   = {in_memtoreg, in_regwrite, in_alu, in_memdata, in_wreg};
  // flush discards the offered beat, so it never counts as accepted into storage
  assign w_acc     = in_valid & r_in_ready & ~flush;
  assign w_pop     = r_h_valid & out_ready;
  assign w_ld_h_s  = w_pop & r_s_valid;
  assign w_ld_h_in = w_acc & ~r_s_valid & (w_pop | ~r_h_valid);
  assign w_ld_s_in = w_acc & (w_pop ? r_s_valid : r_h_valid);
  // with S full, H is always full next; otherwise H keeps an unpopped beat or takes the new one
  assign w_h_nxt   = ~flush & (r_s_valid | w_acc | (r_h_valid & ~w_pop));
  assign w_s_nxt   = ~flush & (w_pop ? (r_s_valid & w_acc) : (r_s_valid | (r_h_valid & w_acc)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_valid   <= 1'b0;
      r_s_valid   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_h_pl      <= '0;
      r_s_pl      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_h_valid  <= w_h_nxt;
      r_s_valid  <= w_s_nxt;
      r_in_ready <= ~w_s_nxt;
      if (w_ld_h_s) r_h_pl <= r_s_pl;
      else if (w_ld_h_in) r_h_pl <= w_in_pl;
      if (w_ld_s_in) r_s_pl <= w_in_pl;
      if (r_h_valid && !out_ready && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  assign in_ready     = r_in_ready;
  assign out_valid    = r_h_valid;
  assign out_memtoreg = r_h_pl[PW-1];
  assign out_regwrite = r_h_valid & r_h_pl[PW-2] & (|out_wreg);
  assign out_alu      = r_h_pl[REG_W+DATA_W +: DATA_W];
  assign out_memdata  = r_h_pl[REG_W +: DATA_W];
  assign out_wreg     = r_h_pl[REG_W-1:0];
  assign wb_data      = out_memtoreg ? out_memdata : out_alu;
  assign stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_memwb_skid_stage.sv
// tb_memwb_skid_stage: directed self-checking bench for memwb_skid_stage
module tb_memwb_skid_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_memtoreg, in_regwrite, flush, out_ready;
  logic [31:0] in_alu, in_memdata;
  logic [4:0]  in_wreg;
  logic        in_ready, out_valid, out_memtoreg, out_regwrite;
  logic [31:0] out_alu, out_memdata, wb_data;
  logic [4:0]  out_wreg;
  logic [15:0] stall_cnt;
  logic        in_ready6, out_valid6, out_memtoreg6, out_regwrite6;
  logic [31:0] out_alu6, out_memdata6, wb_data6;
  logic [4:0]  out_wreg6;
  logic [1:0]  stall_cnt6;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  memwb_skid_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_memtoreg(in_memtoreg),
    .in_regwrite(in_regwrite), .in_alu(in_alu), .in_memdata(in_memdata), .in_wreg(in_wreg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_memtoreg(out_memtoreg),
    .out_regwrite(out_regwrite), .out_alu(out_alu), .out_memdata(out_memdata), .out_wreg(out_wreg),
    .wb_data(wb_data), .stall_cnt(stall_cnt)
  );
  memwb_skid_stage #(.CNT_W(2)) u6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .in_memtoreg(in_memtoreg),
    .in_regwrite(in_regwrite), .in_alu(in_alu), .in_memdata(in_memdata), .in_wreg(in_wreg),
    .flush(flush), .out_valid(out_valid6), .out_ready(out_ready), .out_memtoreg(out_memtoreg6),
    .out_regwrite(out_regwrite6), .out_alu(out_alu6), .out_memdata(out_memdata6), .out_wreg(out_wreg6),
    .wb_data(wb_data6), .stall_cnt(stall_cnt6)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [31:0] alu, input logic [31:0] md, input logic [4:0] wr,
                      input logic rw, input logic m2r);
    in_valid = 1'b1; in_alu = alu; in_memdata = md; in_wreg = wr; in_regwrite = rw; in_memtoreg = m2r;
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_memtoreg = 1'b0; in_regwrite = 1'b0; flush = 1'b0;
    out_ready = 1'b1; in_alu = '0; in_memdata = '0; in_wreg = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_regwrite", 64'(out_regwrite), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    rst = 1'b0;
    tick();
    // single beat, one-cycle latency
    beat(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_wb_data", 64'(wb_data), 64'h1234);
    chk("t1_wreg", 64'(out_wreg), 64'd5);
    chk("t1_regwrite", 64'(out_regwrite), 64'd1);
    tick();
    chk("t1_valid_after", 64'(out_valid), 64'd0);
    // back-pressure: A lands in H, B in S
    out_ready = 1'b0;
    beat(32'd1, 32'h0, 5'd1, 1'b1, 1'b0);
    tick();
    chk("t2_ready_a", 64'(in_ready), 64'd1);
    beat(32'd2, 32'h0, 5'd2, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t2_ready_b", 64'(in_ready), 64'd0);
    chk("t2_head_a", 64'(out_alu), 64'd1);
    chk("t2_stall1", 64'(stall_cnt), 64'd1);
    tick();
    chk("t2_stall2", 64'(stall_cnt), 64'd2);
    chk("t2_hold_a", 64'(out_alu), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("t2_head_b", 64'(out_alu), 64'd2);
    chk("t2_valid_b", 64'(out_valid), 64'd1);
    chk("t2_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("t2_empty", 64'(out_valid), 64'd0);
    chk("t2_stall_final", 64'(stall_cnt), 64'd2);
    // r0 guard
    out_ready = 1'b0;
    beat(32'h55, 32'hDEADBEEF, 5'd0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_regwrite", 64'(out_regwrite), 64'd0);
    chk("t3_wb_data", 64'(wb_data), 64'hDEADBEEF);
    out_ready = 1'b1;
    tick();
    chk("t3_popped", 64'(out_valid), 64'd0);
    chk("t3_stall", 64'(stall_cnt), 64'd2);
    // flush with both entries full plus an incoming beat
    out_ready = 1'b0;
    beat(32'h10, 32'h0, 5'd3, 1'b1, 1'b0);
    tick();
    beat(32'h11, 32'h0, 5'd3, 1'b1, 1'b0);
    tick();
    chk("t4_full", 64'(in_ready), 64'd0);
    beat(32'hCC, 32'h0, 5'd7, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    chk("t4_flush_valid", 64'(out_valid), 64'd0);
    chk("t4_flush_ready", 64'(in_ready), 64'd1);
    chk("t4_flush_regwrite", 64'(out_regwrite), 64'd0);
    chk("t4_flush_stall", 64'(stall_cnt), 64'd4);
    // offered while in_ready=1 and flush=1: must still be dropped
    tick();
    chk("t4_c_dropped", 64'(out_valid), 64'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    beat(32'hDD, 32'h0, 5'd4, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t4_d_valid", 64'(out_valid), 64'd1);
    chk("t4_d_alu", 64'(out_alu), 64'hDD);
    chk("t4_d_regwrite", 64'(out_regwrite), 64'd1);
    tick();
    chk("t4_d_popped", 64'(out_valid), 64'd0);
    chk("t4_stall", 64'(stall_cnt), 64'd4);
    // async reset mid-cycle with both entries full
    out_ready = 1'b0;
    beat(32'h20, 32'h0, 5'd8, 1'b1, 1'b0);
    tick();
    beat(32'h21, 32'h0, 5'd9, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t5_pre_ready", 64'(in_ready), 64'd0);
    chk("t5_pre_stall", 64'(stall_cnt), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd1);
    chk("t5_stall", 64'(stall_cnt), 64'd0);
    chk("t5_regwrite", 64'(out_regwrite), 64'd0);
    #1 rst = 1'b0;
    tick();
    chk("t5_dropped", 64'(out_valid), 64'd0);
    // saturating counter on the CNT_W=2 instance
    beat(32'h66, 32'h0, 5'd6, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t6_valid", 64'(out_valid6), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("t6_cnt2_%0d", k), 64'(stall_cnt6), 64'(k > 3 ? 3 : k));
      chk($sformatf("t6_cnt16_%0d", k), 64'(stall_cnt), 64'(k));
    end
    out_ready = 1'b1;
    tick();
    chk("t6_popped", 64'(out_valid6), 64'd0);
    chk("t6_held", 64'(stall_cnt6), 64'd3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
